// File: rtl/digit_scan_mux_pkg.sv
// Shared definitions for the digit scan multiplexer: blank code and
// leading-zero blanking mask helper.
package digit_scan_mux_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam int unsigned MAX_DIG = 8;

  // Walk from the top digit down; a zero stays blanked only while every
  // higher digit is blanked too. Digit 0 is never visited.
  function automatic logic [MAX_DIG-1:0] lzb_mask(
    input logic [4*MAX_DIG-1:0] disp,
    input int unsigned          ndig,
    input logic                 lzb
  );
    logic               lead;
    logic [MAX_DIG-1:0] m;
    int unsigned        k;
    m    = '0;
    lead = lzb;
    for (int unsigned j = 0; j < MAX_DIG - 1; j++) begin
      k = MAX_DIG - 1 - j;
      if (k < ndig) begin
        if (lead && (disp[4*k +: 4] == 4'd0)) m[k] = 1'b1;
        else                                  lead = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/digit_scan_mux_prescaler.sv
// Slot prescaler and digit index counter for the scan multiplexer;
// both hold while en is low.
module scan_prescaler #(
  parameter  int unsigned DIV  = 1000,
  parameter  int unsigned NDIG = 4,
  localparam int unsigned PW   = $clog2(DIV),
  localparam int unsigned IW   = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [PW-1:0] cnt,
  output logic [IW-1:0] idx,
  output logic          slot_end,
  output logic          frame_end
);

  assign slot_end  = en && (cnt == PW'(DIV - 1));
  assign frame_end = slot_end && (idx == IW'(NDIG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= frame_end ? '0 : idx + 1'b1;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexed BCD scan driver feeding a single 7-segment decoder,
// with tear-free frame updates, leading-zero and guard blanking.
module digit_scan_mux
  import digit_scan_mux_pkg::*;
#(
  parameter int unsigned NDIG  = 4,
  parameter int unsigned DIV   = 1000,
  parameter int unsigned GUARD = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic [4*NDIG-1:0] bcd_in,
  input  logic              lzb,
  output logic [3:0]        bcd_out,
  output logic [NDIG-1:0]   dig_sel,
  output logic              frame
);

  localparam int unsigned PW = $clog2(DIV);
  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [PW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic                   slot_end;
  logic                   frame_end;
  logic [4*NDIG-1:0]      pending;
  logic [4*NDIG-1:0]      display;
  logic                   pending_valid;
  logic [4*MAX_DIG-1:0]   disp_pad;
  logic [MAX_DIG-1:0]     mask_all;
  logic [3:0]             cur_digit;
  logic                   cur_blank;
  logic [NDIG-1:0]        sel_next;

  scan_prescaler #(
    .DIV  (DIV),
    .NDIG (NDIG)
  ) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cnt       (cnt),
    .idx       (idx),
    .slot_end  (slot_end),
    .frame_end (frame_end)
  );

  always_comb begin
    disp_pad                 = '0;
    disp_pad[4*NDIG-1:0]     = display;
    mask_all                 = lzb_mask(disp_pad, NDIG, lzb);
    cur_digit                = display[{idx, 2'b00} +: 4];
    cur_blank                = mask_all[idx];
    sel_next                 = '0;
    sel_next[idx]            = 1'b1;
  end

  // pending always tracks the latest LOAD, so a boundary bypass also refreshes
  // it and a later transfer without a new LOAD leaves display unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending       <= '0;
      display       <= '0;
      pending_valid <= 1'b0;
    end else begin
      if (load) pending <= bcd_in;
      if (frame_end) begin
        pending_valid <= 1'b0;
        if (load)               display <= bcd_in;
        else if (pending_valid) display <= pending;
      end else if (load) begin
        pending_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_sel <= '0;
      bcd_out <= BLANK_CODE;
      frame   <= 1'b0;
    end else begin
      frame <= frame_end;
      if (!en || (cnt < PW'(GUARD))) begin
        dig_sel <= '0;
        bcd_out <= BLANK_CODE;
      end else begin
        dig_sel <= sel_next;
        bcd_out <= cur_blank ? BLANK_CODE : cur_digit;
      end
    end
  end

endmodule
